// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of a 4-bit combinational ALU: command FIFO, one-at-a-time issue,
// captured result on a valid/ready port. Define ALU_CMD_ISSUE_ACC_EN for the chaining accumulator.
module alu_cmd_issue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_opcode_i,
  input  logic [3:0]               cmd_a_i,
  input  logic [3:0]               cmd_b_i,
  input  logic                     cmd_use_acc_i,
  output logic [3:0]               alu_a_o,
  output logic [3:0]               alu_b_o,
  output logic [2:0]               alu_opcode_o,
  input  logic [3:0]               alu_result_i,
  input  logic                     alu_carry_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [3:0]               res_data_o,
  output logic                     res_carry_o,
  output logic                     res_zero_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
`ifdef ALU_CMD_ISSUE_ACC_EN
  localparam int unsigned EntryW = 12;
`else
  localparam int unsigned EntryW = 11;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e            state_q, state_d;
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              ready_en_q;
  logic              push, pop, fifo_empty;
  logic [EntryW-1:0] wr_entry, head;
  logic [2:0]        head_op;
  logic [3:0]        head_a, head_b;
  logic [2:0]        op_q, op_d;
  logic [3:0]        a_q, a_d;
  logic [3:0]        b_q, b_d;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_zero_q, res_zero_d;

  assign head = mem_q[rd_ptr_q];

`ifdef ALU_CMD_ISSUE_ACC_EN
  logic [3:0] acc_q, acc_d;

  assign wr_entry = {cmd_opcode_i, cmd_a_i, cmd_b_i, cmd_use_acc_i};
  assign head_op  = head[11:9];
  // Operand A is resolved at pop time; pops never coincide with ISSUE, so acc is already final.
  assign head_a   = head[0] ? acc_q : head[8:5];
  assign head_b   = head[4:1];
`else
  logic unused_use_acc;

  assign unused_use_acc = cmd_use_acc_i;
  assign wr_entry = {cmd_opcode_i, cmd_a_i, cmd_b_i};
  assign head_op  = head[10:8];
  assign head_a   = head[7:4];
  assign head_b   = head[3:0];
`endif

  // No push bypass: a full FIFO refuses even when a pop happens in the same cycle.
  assign cmd_ready_o = ready_en_q & (level_q != LvlW'(DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign push        = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
`ifdef ALU_CMD_ISSUE_ACC_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        res_data_d  = alu_result_i;
        res_carry_d = alu_carry_i;
        res_zero_d  = (alu_result_i == 4'h0);
        res_valid_d = 1'b1;
`ifdef ALU_CMD_ISSUE_ACC_EN
        acc_d       = alu_result_i;
`endif
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (pop) begin
      op_d     = head_op;
      a_d      = head_a;
      b_d      = head_b;
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
    end
  end

`ifdef ALU_CMD_ISSUE_ACC_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign alu_opcode_o = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_carry_o  = res_carry_q;
  assign res_zero_o   = res_zero_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed self-checking bench for alu_cmd_issue with a behavioural 4-bit ALU attached.
module tb_alu_cmd_issue;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_opcode;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_use_acc;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_carry, res_zero;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [2:0] bp_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [3:0] bp_a  [6] = '{4'd1, 4'd9, 4'd12, 4'd5, 4'd5, 4'd7};
  logic [3:0] bp_b  [6] = '{4'd1, 4'd3, 4'd10, 4'd2, 4'd3, 4'd7};
  logic [3:0] bp_d  [6] = '{4'd2, 4'd6, 4'd8, 4'd7, 4'd10, 4'd0};
  logic       bp_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_opcode_i  (cmd_opcode),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .cmd_use_acc_i (cmd_use_acc),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_opcode_o  (alu_opcode),
    .alu_result_i  (alu_result),
    .alu_carry_i   (alu_carry),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_data_o    (res_data),
    .res_carry_o   (res_carry),
    .res_zero_o    (res_zero),
    .fifo_level_o  (fifo_level)
  );

  // Behavioural ALU: carry is the borrow on sub, 0 otherwise.
  always_comb begin
    alu_result = 4'h0;
    alu_carry  = 1'b0;
    case (alu_opcode)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = ~alu_a;
      default: alu_result = 4'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input logic [3:0] d,
                           input logic c, input logic z);
    check({tag, ".res_valid"}, 8'(res_valid), 8'(v));
    check({tag, ".res_data"},  8'(res_data),  8'(d));
    check({tag, ".res_carry"}, 8'(res_carry), 8'(c));
    check({tag, ".res_zero"},  8'(res_zero),  8'(z));
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".timeout"}, 8'(res_valid), 8'd1);
  endtask

  // One command into an idle, empty block with res_ready held high.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic use_acc, input logic [3:0] exp_a,
                         input logic [3:0] exp_d, input logic exp_c, input logic exp_z);
    res_ready = 1'b1;
    drive(op, a, b, use_acc);
    tick();
    cmd_valid = 1'b0;
    check({tag, ".level"}, 8'(fifo_level), 8'd1);
    tick();
    check({tag, ".alu_a"},      8'(alu_a),      8'(exp_a));
    check({tag, ".alu_b"},      8'(alu_b),      8'(b));
    check({tag, ".alu_opcode"}, 8'(alu_opcode), 8'(op));
    check({tag, ".issue_valid"}, 8'(res_valid), 8'd0);
    tick();
    check_res(tag, 1'b1, exp_d, exp_c, exp_z);
    tick();
    check({tag, ".consumed"}, 8'(res_valid), 8'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst_ni      = 1'b0;
    cmd_valid   = 1'b1;
    cmd_opcode  = 3'($urandom);
    cmd_a       = 4'($urandom);
    cmd_b       = 4'($urandom);
    cmd_use_acc = 1'($urandom);
    res_ready   = 1'($urandom);
    repeat (3) tick();
    check("rst.cmd_ready",  8'(cmd_ready),  8'd0);
    check("rst.level",      8'(fifo_level), 8'd0);
    check("rst.alu_a",      8'(alu_a),      8'd0);
    check("rst.alu_b",      8'(alu_b),      8'd0);
    check("rst.alu_opcode", 8'(alu_opcode), 8'd0);
    check_res("rst", 1'b0, 4'd0, 1'b0, 1'b0);

    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
    res_ready   = 1'b0;
    rst_ni      = 1'b1;
    tick();
    check("rel.cmd_ready", 8'(cmd_ready),  8'd1);
    check("rel.level",     8'(fifo_level), 8'd0);
    check("rel.res_valid", 8'(res_valid),  8'd0);

    run_one("add",        3'd0, 4'd3, 4'd4, 1'b0, 4'd3, 4'd7,  1'b0, 1'b0);
    run_one("sub_borrow", 3'd1, 4'd2, 4'd5, 1'b0, 4'd2, 4'd13, 1'b1, 1'b0);
    run_one("sub_zero",   3'd1, 4'd5, 4'd5, 1'b0, 4'd5, 4'd0,  1'b0, 1'b1);

    // Backpressure: one result held, four queued, sixth command stalled
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(bp_op[i], bp_a[i], bp_b[i], 1'b0);
      tick();
    end
    check("bp.cmd_ready", 8'(cmd_ready),  8'd0);
    check("bp.level",     8'(fifo_level), 8'd4);
    check_res("bp.hold", 1'b1, bp_d[0], 1'b0, bp_z[0]);
    tick();
    check("bp.level2", 8'(fifo_level), 8'd4);
    check_res("bp.stable", 1'b1, bp_d[0], 1'b0, bp_z[0]);
    res_ready = 1'b1;
    tick();
    check("bp.pop_level", 8'(fifo_level), 8'd3);
    check("bp.pop_valid", 8'(res_valid),  8'd0);
    check("bp.pop_ready", 8'(cmd_ready),  8'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp.push6_level", 8'(fifo_level), 8'd4);
    for (int i = 1; i < 6; i++) begin
      wait_valid($sformatf("bp.r%0d", i));
      check_res($sformatf("bp.r%0d", i), 1'b1, bp_d[i], 1'b0, bp_z[i]);
      tick();
    end
    check("bp.drained_valid", 8'(res_valid), 8'd0);
    repeat (2) tick();
    check("bp.no_dup", 8'(res_valid), 8'd0);
    check("bp.empty",  8'(fifo_level), 8'd0);

    // Accumulator chain
    run_one("chain0", 3'd0, 4'd1, 4'd2, 1'b0, 4'd1, 4'd3, 1'b0, 1'b0);
`ifdef ALU_CMD_ISSUE_ACC_EN
    run_one("chain1", 3'd0, 4'd9, 4'd5, 1'b1, 4'd3, 4'd8, 1'b0, 1'b0);
    run_one("chain2", 3'd4, 4'd6, 4'd0, 1'b1, 4'd8, 4'd7, 1'b0, 1'b0);
`else
    run_one("chain1", 3'd0, 4'd9, 4'd5, 1'b1, 4'd9, 4'd14, 1'b0, 1'b0);
    run_one("chain2", 3'd4, 4'd6, 4'd0, 1'b1, 4'd6, 4'd9,  1'b0, 1'b0);
`endif

    // Reset while holding a result with three commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, 4'(i + 1), 4'd1, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    check("mid.level", 8'(fifo_level), 8'd3);
    check_res("mid.hold", 1'b1, 4'd2, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid.rst_valid", 8'(res_valid),  8'd0);
    check("mid.rst_level", 8'(fifo_level), 8'd0);
    check("mid.rst_ready", 8'(cmd_ready),  8'd0);
    check("mid.rst_data",  8'(res_data),   8'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    res_ready = 1'b1;
    check("mid.rel_ready", 8'(cmd_ready), 8'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mid.stale%0d", i), 8'(res_valid), 8'd0);
    end
    check("mid.level_end", 8'(fifo_level), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
